sdq_alloc_ctrl: RTL

- Allocation and replay controller for the 17-entry x 64-bit store data queue (SDQ) array in the non-blocking D-cache miss path.
- Accepts store data from missing stores and allocates the lowest free SDQ slot, returning its index to the MSHR.
- Writes the data through the array's W0 port.
- Later services MSHR replay requests by reading through the array's R0 port, presenting a registered response, and freeing the slot once the response is consumed.

---
 rtl/sdq_alloc_ctrl_pkg.sv | 12 +
 rtl/sdq_alloc_ctrl_if.sv | 39 +++
 rtl/sdq_alloc_ctrl_free_list.sv | 49 ++++
 rtl/sdq_alloc_ctrl.sv | 78 +++++++
 4 files changed

// File: rtl/sdq_alloc_ctrl_pkg.sv
// rtl/sdq_alloc_ctrl_pkg.sv - shared sizes and types for the store data queue controller
package sdq_pkg;

  localparam int SDQ_ENTRIES = 17;
  localparam int SDQ_DATA_W  = 64;
  localparam int SDQ_ID_W    = 5;

  typedef logic [SDQ_ID_W-1:0]   sdq_id_t;
  typedef logic [SDQ_DATA_W-1:0] sdq_data_t;
  typedef logic [SDQ_ENTRIES-1:0] sdq_mask_t;

endpackage

// File: rtl/sdq_alloc_ctrl_if.sv
// rtl/sdq_alloc_ctrl_if.sv - enqueue, replay, response and array port bundle
interface sdq_alloc_ctrl_if;
  import sdq_pkg::*;

  logic      enq_valid;
  logic      enq_ready;
  sdq_data_t enq_data;
  sdq_id_t   enq_id;
  logic      rpl_valid;
  logic      rpl_ready;
  sdq_id_t   rpl_id;
  logic      resp_valid;
  logic      resp_ready;
  sdq_data_t resp_data;
  sdq_id_t   resp_id;
  sdq_id_t   mem_R0_addr;
  logic      mem_R0_en;
  sdq_data_t mem_R0_data;
  sdq_id_t   mem_W0_addr;
  logic      mem_W0_en;
  sdq_data_t mem_W0_data;
  sdq_id_t   occupancy;
  logic      err_bad_replay;

  modport slave (
    input  enq_valid, enq_data, rpl_valid, rpl_id, resp_ready, mem_R0_data,
    output enq_ready, enq_id, rpl_ready, resp_valid, resp_data, resp_id,
           mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data,
           occupancy, err_bad_replay
  );

  modport master (
    output enq_valid, enq_data, rpl_valid, rpl_id, resp_ready, mem_R0_data,
    input  enq_ready, enq_id, rpl_ready, resp_valid, resp_data, resp_id,
           mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data,
           occupancy, err_bad_replay
  );

endinterface

// File: rtl/sdq_alloc_ctrl_free_list.sv
// rtl/sdq_alloc_ctrl_free_list.sv - free mask, lowest-free-slot encoder and occupancy count
module sdq_free_list
  import sdq_pkg::*;
#(
  parameter int ENTRIES = SDQ_ENTRIES,
  parameter int ID_W    = SDQ_ID_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc,
  input  logic               free_en,
  input  logic [ID_W-1:0]    free_id,
  output logic [ENTRIES-1:0] free_mask,
  output logic               enq_ready,
  output logic [ID_W-1:0]    enq_id,
  output logic [ID_W-1:0]    occupancy
);

  logic [ENTRIES-1:0] mask_nxt;

  assign enq_ready = |free_mask;

  // Scan from the top so the lowest set bit wins; an empty mask leaves id 0.
  always_comb begin
    enq_id = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (free_mask[i]) enq_id = ID_W'(i);
    end
  end

  // The allocated and freed slots are always distinct: a slot being freed is not free.
  always_comb begin
    mask_nxt = free_mask;
    if (alloc)   mask_nxt[enq_id]  = 1'b0;
    if (free_en) mask_nxt[free_id] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_mask <= '1;
      occupancy <= '0;
    end else begin
      free_mask <= mask_nxt;
      if (alloc && !free_en)      occupancy <= occupancy + ID_W'(1);
      else if (!alloc && free_en) occupancy <= occupancy - ID_W'(1);
    end
  end

endmodule

// File: rtl/sdq_alloc_ctrl.sv
// rtl/sdq_alloc_ctrl.sv - store data queue slot allocation, array steering and replay response
module sdq_alloc_ctrl
  import sdq_pkg::*;
#(
  parameter int ENTRIES = SDQ_ENTRIES,
  parameter int DATA_W  = SDQ_DATA_W,
  parameter int ID_W    = SDQ_ID_W
) (
  input  logic              clock,
  input  logic              reset,
  sdq_alloc_ctrl_if.slave   bus
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] free_mask;
  logic               enq_fire;
  logic               rpl_fire;
  logic               resp_fire;
  logic               rpl_bad;
  logic               rpl_good;
  logic               resp_valid_q;
  logic [DATA_W-1:0]  resp_data_q;
  logic [ID_W-1:0]    resp_id_q;
  logic               err_q;

  sdq_free_list #(.ENTRIES(ENTRIES), .ID_W(ID_W)) u_free_list (
    .clock     (clock),
    .reset     (reset),
    .alloc     (enq_fire),
    .free_en   (resp_fire),
    .free_id   (resp_id_q),
    .free_mask (free_mask),
    .enq_ready (bus.enq_ready),
    .enq_id    (bus.enq_id),
    .occupancy (bus.occupancy)
  );

  assign enq_fire  = bus.enq_valid && bus.enq_ready;
  assign resp_fire = resp_valid_q && bus.resp_ready;
  assign bus.rpl_ready = !resp_valid_q || bus.resp_ready;
  assign rpl_fire  = bus.rpl_valid && bus.rpl_ready;

  // Replaying an out-of-range or unallocated slot is swallowed and flagged.
  assign rpl_bad  = (bus.rpl_id > LAST_ID) ? 1'b1 : free_mask[bus.rpl_id];
  assign rpl_good = rpl_fire && !rpl_bad;

  assign bus.mem_W0_en   = enq_fire;
  assign bus.mem_W0_addr = bus.enq_id;
  assign bus.mem_W0_data = bus.enq_data;

  assign bus.mem_R0_en   = rpl_good;
  assign bus.mem_R0_addr = rpl_good ? bus.rpl_id : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      if (rpl_good) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= bus.mem_R0_data;
        resp_id_q    <= bus.rpl_id;
      end else if (resp_fire) begin
        resp_valid_q <= 1'b0;
      end
      if (rpl_fire && rpl_bad) err_q <= 1'b1;
    end
  end

  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_id        = resp_id_q;
  assign bus.err_bad_replay = err_q;

endmodule
